// File: rtl/frame_buffer_arbiter_pkg.sv
// Shared defaults and grant encoding for the frame buffer arbiter.
package frame_buffer_arbiter_pkg;

  localparam int ADDR_W_DEF     = 19;
  localparam int DATA_W_DEF     = 12;
  localparam int FIFO_DEPTH_DEF = 16;

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_RD   = 2'd1,
    GNT_WR   = 2'd2
  } gnt_t;

endpackage

// File: rtl/frame_buffer_arbiter_fifo.sv
// Camera write buffer: register-based sync FIFO with level/full/empty.
module fb_wr_fifo #(
  parameter int W     = 31,
  parameter int DEPTH = 16
) (
  input  logic                   clk25,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  // extra MSB separates full from empty when the index bits match
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                 (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[PW-1:0]];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk25) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= wdata;
  end

endmodule

// File: rtl/frame_buffer_arbiter.sv
// Single-port frame buffer shared by a VGA reader (priority)
// and a buffered camera writer.
module frame_buffer_arbiter
  import frame_buffer_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                        clk25,
  input  logic                        rst_n,
  input  logic                        cam_wr_valid,
  output logic                        cam_wr_ready,
  input  logic [ADDR_W-1:0]           cam_wr_addr,
  input  logic [DATA_W-1:0]           cam_wr_data,
  input  logic                        vga_rd_en,
  input  logic [ADDR_W-1:0]           vga_rd_addr,
  output logic [DATA_W-1:0]           vga_rd_data,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_we,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic [15:0]                 drop_cnt,
  input  logic                        clr_status
);

  localparam int EW = ADDR_W + DATA_W;

  logic              run_q;
  logic              full;
  logic              empty;
  logic              push;
  logic              drop;
  logic [EW-1:0]     head;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  gnt_t              gnt;

  fb_wr_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk25 (clk25),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({cam_wr_addr, cam_wr_data}),
    .pop   (gnt == GNT_WR),
    .rdata (head),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );

  assign {head_addr, head_data} = head;

  // run_q holds ready low until the first edge after reset
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  assign cam_wr_ready = run_q && !full;
  assign push         = cam_wr_valid && cam_wr_ready;
  assign drop         = cam_wr_valid && run_q && full;

  always_comb begin
    gnt = GNT_IDLE;
    if (!run_q)         gnt = GNT_IDLE;
    else if (vga_rd_en) gnt = GNT_RD;
    else if (!empty)    gnt = GNT_WR;
  end

  assign mem_we      = (gnt == GNT_WR);
  assign mem_addr    = mem_we ? head_addr : vga_rd_addr;
  assign mem_wdata   = head_data;
  assign vga_rd_data = mem_rdata;

  // a drop in the clearing cycle wins: status restarts at one drop
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_status)            drop_cnt <= 16'd1;
      else if (drop_cnt != '1)   drop_cnt <= drop_cnt + 16'd1;
    end else if (clr_status) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: doc/frame_buffer_arbiter.md
FRAME_BUFFER_ARBITER -- requirements
Module: frame_buffer_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  ADDR_W, 19, frame buffer address width.
  DATA_W, 12, pixel width (RGB444).
  FIFO_DEPTH, 16, write-buffer entries (power of two).
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk25  in  1  single clock, all logic on rising edge.
  rst_n  in  1  asynchronous active-low reset.
  cam_wr_valid  in  1  camera write request.
  cam_wr_ready  out  1  write-buffer can accept.
  cam_wr_addr  in  ADDR_W  camera pixel address.
  cam_wr_data  in  DATA_W  camera pixel.
  vga_rd_en  in  1  VGA read request this cycle.
  vga_rd_addr  in  ADDR_W  VGA read address.
  vga_rd_data  out  DATA_W  read pixel, valid 1 cycle after vga_rd_en.
  mem_addr  out  ADDR_W  single-port RAM address.
  mem_we  out  1  RAM write enable.
  mem_wdata  out  DATA_W  RAM write data.
  mem_rdata  in  DATA_W  RAM read data, 1-cycle synchronous read.
  fifo_level  out  $clog2(FIFO_DEPTH)+1  entries buffered.
  overflow  out  1  sticky: write dropped.
  drop_cnt  out  16  dropped-write count, saturating.
  clr_status  in  1  clears overflow and drop_cnt.

Function
REQ-003 The block SHALL share one single-port RAM between the VGA reader (priority) and the camera writer (buffered).
REQ-004 A camera write SHALL be accepted into the FIFO when cam_wr_valid and cam_wr_ready are both 1.
REQ-005 cam_wr_ready SHALL equal (FIFO not full), independent of a same-cycle pop.
REQ-006 Arbiter states SHALL be GNT_IDLE, GNT_RD, GNT_WR, re-evaluated every cycle: vga_rd_en=1 -> GNT_RD; else FIFO non-empty -> GNT_WR; else GNT_IDLE.
REQ-007 In GNT_RD: mem_addr=vga_rd_addr, mem_we=0; the FIFO SHALL NOT pop.
REQ-008 In GNT_WR: mem_addr/mem_wdata SHALL equal the FIFO head, mem_we=1, and the head SHALL pop at the clock edge.
REQ-009 In GNT_IDLE: mem_we=0, mem_addr=vga_rd_addr.
REQ-010 mem_addr, mem_we and mem_wdata SHALL be combinational from arbiter inputs and the registered FIFO head.
REQ-011 vga_rd_data SHALL equal mem_rdata, i.e. 1 cycle after vga_rd_en, with no added latency.
REQ-012 Simultaneous push and pop SHALL leave fifo_level unchanged and preserve FIFO order.
REQ-013 A cycle with cam_wr_valid=1 while full SHALL drop the write, set overflow, and increment drop_cnt (saturating at 0xFFFF).
REQ-014 clr_status=1 SHALL clear overflow and drop_cnt next edge; a simultaneous drop SHALL take priority (overflow=1, drop_cnt=1).
REQ-015 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be distinguished by an extra pointer bit.
REQ-016 Writes to the same address SHALL reach RAM in acceptance order; no read-after-write forwarding is provided.

Reset
REQ-017 While rst_n=0: FIFO empty, fifo_level=0, cam_wr_ready=0, mem_we=0, overflow=0, drop_cnt=0, state GNT_IDLE.
REQ-018 cam_wr_ready SHALL rise on the first edge after rst_n deasserts.
REQ-019 Reset mid-operation SHALL discard buffered writes immediately, without completing a pending RAM write.

Structure
REQ-020 A shared package SHALL hold ADDR_W/DATA_W defaults and the arbiter state enumeration.
REQ-021 The FIFO SHALL be one sub-module, fb_wr_fifo (sync FIFO with level, full, empty).

Verification
REQ-022 Idle RAM: 3 camera writes (addr 0x10..0x12, data 0xABC..0xABE) -> mem_we=1 on 3 consecutive cycles, in order, fifo_level returns to 0.
REQ-023 vga_rd_en held for 640 cycles with 5 pending writes -> mem_we=0 throughout, writes drain in the 5 cycles after vga_rd_en falls.
REQ-024 Fill: 16 writes during a read burst -> cam_wr_ready=0; 17th write -> overflow=1, drop_cnt=1, entry 17 never reaches RAM.
REQ-025 Read latency: vga_rd_addr=0x00100 with RAM preloaded to 0x5A3 -> vga_rd_data=0x5A3 exactly 1 cycle later.
REQ-026 clr_status coincident with a drop -> overflow=1, drop_cnt=1; clr_status alone -> both 0.
REQ-027 rst_n pulsed low with 8 entries buffered -> fifo_level=0, mem_we=0 asynchronously, and no further RAM writes.
